// File: rtl/dmem_hs.sv
// dmem_hs: single-port byte-addressable data memory behind a req/busy/done
// handshake. Supports byte/half/word stores with lane enables, sign- or
// zero-extended loads, a configurable number of wait states and fault
// reporting for misaligned, out-of-range and illegal-size accesses.
module dmem_hs #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        fault
);

    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // Access captured at acceptance; inputs may change freely afterwards.
    logic             we_p0;
    logic [1:0]       size_p0;
    logic             uns_p0;
    logic [IDX_W+1:0] a_p0;
    logic [31:0]      wd_p0;
    logic             fault_p0;

    // Fields of the access being completed. With zero wait states the
    // access commits on its acceptance edge, so the live inputs are used.
    logic             src_we;
    logic [1:0]       src_size;
    logic             src_uns;
    logic [IDX_W+1:0] src_a;
    logic [31:0]      src_wd;
    logic             src_fault;
    logic [IDX_W-1:0] widx;
    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic [31:0]      rword;
    logic             enter_resp;
    logic             mem_wr;

    logic [31:0] mem [DEPTH];

    // Any one condition rejects the access; there is no address aliasing.
    function automatic logic acc_fault(input logic [1:0] sz, input logic [31:0] ad);
        logic f;
        case (sz)
            2'b01:   f = ad[0];
            2'b10:   f = |ad[1:0];
            2'b11:   f = 1'b1;
            default: f = 1'b0;
        endcase
        if ({2'b00, ad[31:2]} >= 32'(DEPTH))
            f = 1'b1;
        return f;
    endfunction

    // Byte lanes touched by a store.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Right-aligned store data replicated so every enabled lane sees it.
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed byte/half, right-align it and extend.
    function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] lo,
                                             input logic u, input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = u ? $signed({24'd0, b}) : 32'(b);
            2'b01:   r = u ? $signed({16'd0, h}) : 32'(h);
            default: r = $signed(w);
        endcase
        return r;
    endfunction

    always_comb begin
        if (state == IDLE) begin
            src_we    = we;
            src_size  = size;
            src_uns   = uns;
            src_a     = a[IDX_W+1:0];
            src_wd    = wd;
            src_fault = acc_fault(size, a);
        end else begin
            src_we    = we_p0;
            src_size  = size_p0;
            src_uns   = uns_p0;
            src_a     = a_p0;
            src_wd    = wd_p0;
            src_fault = fault_p0;
        end
    end

    assign widx       = src_a[IDX_W+1:2];
    assign wmask      = lane_mask(src_size, src_a[1:0]);
    assign wdata      = lane_data(src_size, src_wd);
    assign rword      = mem[widx];
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign mem_wr     = enter_resp && !reset && src_we && !src_fault;

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS_M1;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0)
                    state_nxt = RESP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            RESP: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, wait counter and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd    <= 32'd0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                fault <= src_fault;
                rd    <= (src_fault || src_we) ? 32'd0
                                               : load_ext(src_size, src_a[1:0], src_uns, rword);
            end
        end
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_p0    <= we;
            size_p0  <= size;
            uns_p0   <= uns;
            a_p0     <= a[IDX_W+1:0];
            wd_p0    <= wd;
            fault_p0 <= acc_fault(size, a);
        end
    end

    // RAM array: lane-masked store committed on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int l = 0; l < 4; l++)
                if (wmask[l])
                    mem[widx][8*l +: 8] <= wdata[8*l +: 8];
        end
    end

endmodule
